// File: rtl/snake_datapath.sv
// Snake game datapath: head position/direction, 2x2 head-block plot sequencer
// and the frame-rate tick divider that raises go for the control FSM.
module snake_datapath #(
  parameter int         TICK_CYCLES = 833333,
  parameter int         START_X     = 80,
  parameter int         START_Y     = 60,
  parameter logic [2:0] COLOUR      = 3'b010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic       update,
  input  logic       plot,
  input  logic [1:0] dir_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       go
);

  // Control strobes are single-cycle qualifiers with priority ld > update > plot;
  // go is a level request that holds until an update cycle consumes it.

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  localparam logic [7:0] X_START = 8'(START_X);
  localparam logic [6:0] Y_START = 7'(START_Y);
  localparam logic [7:0] X_LAST  = 8'd158;
  localparam logic [6:0] Y_LAST  = 7'd118;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  logic [7:0]    head_x;
  logic [6:0]    head_y;
  logic [1:0]    dir;
  logic [1:0]    pix_cnt;
  logic [TW-1:0] tick_cnt;

  logic          reverse;
  logic [1:0]    dir_nxt;
  logic [7:0]    x_nxt;
  logic [6:0]    y_nxt;
  logic          tick_done;

  // A reversal stays on the same axis (bit 1) but flips the sense (bit 0).
  assign reverse   = (dir_in[1] == dir[1]) && (dir_in[0] != dir[0]);
  assign dir_nxt   = reverse ? dir : dir_in;
  assign tick_done = (tick_cnt == TICK_LAST);

  always_comb begin
    x_nxt = head_x;
    y_nxt = head_y;
    case (dir_nxt)
      DIR_RIGHT: x_nxt = (head_x == X_LAST) ? 8'd0 : head_x + 8'd2;
      DIR_LEFT:  x_nxt = (head_x == 8'd0) ? X_LAST : head_x - 8'd2;
      DIR_UP:    y_nxt = (head_y == 7'd0) ? Y_LAST : head_y - 7'd2;
      DIR_DOWN:  y_nxt = (head_y == Y_LAST) ? 7'd0 : head_y + 7'd2;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_x   <= X_START;
      head_y   <= Y_START;
      dir      <= DIR_RIGHT;
      pix_cnt  <= 2'd0;
      tick_cnt <= '0;
      go       <= 1'b0;
    end else if (ld) begin
      head_x   <= X_START;
      head_y   <= Y_START;
      dir      <= DIR_RIGHT;
      pix_cnt  <= 2'd0;
      tick_cnt <= '0;
      go       <= 1'b0;
    end else begin
      if (update) begin
        head_x <= x_nxt;
        head_y <= y_nxt;
        dir    <= dir_nxt;
      end else if (plot) begin
        pix_cnt <= pix_cnt + 2'd1;
      end
      tick_cnt <= tick_done ? '0 : tick_cnt + TICK_ONE;
      // A fresh tick outranks the update that would otherwise consume go.
      if (tick_done)
        go <= 1'b1;
      else if (update)
        go <= 1'b0;
    end
  end

  assign x_out  = head_x + {7'd0, pix_cnt[0]};
  assign y_out  = head_y + {6'd0, pix_cnt[1]};
  assign colour = COLOUR;

endmodule
